// File: rtl/phasegen_pkg.sv
// kappa3_phase: shared phase constants and execution-mode encoding for phasegen and controller
package kappa3_phase;
  localparam logic [3:0] PH_IF   = 4'b0001;
  localparam logic [3:0] PH_DE   = 4'b0010;
  localparam logic [3:0] PH_EX   = 4'b0100;
  localparam logic [3:0] PH_WB   = 4'b1000;
  localparam logic [3:0] PH_NONE = 4'b0000;
  typedef enum logic [1:0] {
    MODE_IDLE,
    MODE_RUN,
    MODE_STEP_PH,
    MODE_STEP_INST
  } mode_t;
  function automatic logic [3:0] ph_next(input logic [3:0] ph);
    return {ph[2:0], ph[3]};
  endfunction
endpackage

// File: rtl/phasegen_if.sv
// phasegen_if: execution-control, breakpoint and phase signals between front panel/datapath and phasegen
interface phasegen_if #(parameter int XLEN = 32);
  logic            run;
  logic            stop;
  logic            step_phase;
  logic            step_inst;
  logic            mem_busy;
  logic            bp_en;
  logic [XLEN-1:0] bp_addr;
  logic [XLEN-1:0] pc;
  logic [3:0]      cstate;
  logic            running;
  logic            bp_stop;
  modport master (
    output run, stop, step_phase, step_inst, mem_busy, bp_en, bp_addr, pc,
    input  cstate, running, bp_stop
  );
  modport slave (
    input  run, stop, step_phase, step_inst, mem_busy, bp_en, bp_addr, pc,
    output cstate, running, bp_stop
  );
endinterface

// File: rtl/phasegen.sv
// phasegen: one-hot IF/DE/EX/WB phase sequencer with run/stop/step control and a PC breakpoint
module phasegen
  import kappa3_phase::*;
(
  input  logic      clock,
  input  logic      reset,
  phasegen_if.slave bus
);
  mode_t      mode;
  logic [3:0] ph;
  logic       resume;
  logic       stop_pend;
  logic       bp_stop;
  logic       bp_hit;
  logic       active;
  logic       done;
  always_comb begin
    bp_hit = (mode == MODE_RUN || mode == MODE_STEP_INST) && bus.bp_en && ph == PH_IF &&
             bus.pc == bus.bp_addr && !resume;
    active = (mode == MODE_RUN || mode == MODE_STEP_INST) ? !bp_hit : mode == MODE_STEP_PH;
    done   = active && !bus.mem_busy;
  end
  assign bus.cstate  = (active && !reset) ? ph : PH_NONE;
  assign bus.running = mode != MODE_IDLE && !reset;
  assign bus.bp_stop = bp_stop;
  always_ff @(posedge clock) begin
    if (reset) begin
      mode      <= MODE_IDLE;
      ph        <= PH_IF;
      resume    <= 1'b1;
      stop_pend <= 1'b0;
      bp_stop   <= 1'b0;
    end else begin
      if (done) begin
        ph <= ph_next(ph);
        if (ph == PH_IF) resume <= 1'b0;
      end
      case (mode)
        MODE_IDLE: begin
          if (!bus.stop && (bus.run || bus.step_inst || bus.step_phase)) begin
            mode    <= bus.run ? MODE_RUN : bus.step_inst ? MODE_STEP_INST : MODE_STEP_PH;
            resume  <= 1'b1;
            bp_stop <= 1'b0;
          end
        end
        MODE_RUN: begin
          if (bus.stop) stop_pend <= 1'b1;
          if (bp_hit) begin
            mode      <= MODE_IDLE;
            bp_stop   <= 1'b1;
            stop_pend <= 1'b0;
          end else if (done && ph == PH_WB && stop_pend) begin
            mode      <= MODE_IDLE;
            stop_pend <= 1'b0;
          end
        end
        MODE_STEP_PH: begin
          if (done) mode <= MODE_IDLE;
        end
        MODE_STEP_INST: begin
          if (bp_hit) begin
            mode    <= MODE_IDLE;
            bp_stop <= 1'b1;
          end else if (done && ph == PH_WB) begin
            mode <= MODE_IDLE;
          end
        end
        default: mode <= MODE_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_phasegen.sv
// tb_phasegen: directed-step self-checking bench for phasegen
module tb_phasegen;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int checks = 0;
  int errors = 0;
  phasegen_if #(.XLEN(32)) bus ();
  phasegen dut (.clock(clk), .reset(rst), .bus(bus));
  always #5 clk = ~clk;
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [3:0] cs, input logic r, input logic b);
    #1;
    checks++;
    assert (bus.cstate === cs) else begin
      errors++;
      $error("FAIL %s cstate got %b want %b", tag, bus.cstate, cs);
    end
    checks++;
    assert (bus.running === r) else begin
      errors++;
      $error("FAIL %s running got %b want %b", tag, bus.running, r);
    end
    checks++;
    assert (bus.bp_stop === b) else begin
      errors++;
      $error("FAIL %s bp_stop got %b want %b", tag, bus.bp_stop, b);
    end
  endtask
  initial begin
    bus.run = 0; bus.stop = 0; bus.step_phase = 0; bus.step_inst = 0;
    bus.mem_busy = 0; bus.bp_en = 0; bus.bp_addr = '0; bus.pc = '0;
    cyc(); cyc();
    chk("reset", 4'b0000, 0, 0);
    rst = 0; bus.run = 1;
    chk("idle", 4'b0000, 0, 0);
    cyc(); bus.run = 0;
    chk("run_if", 4'b0001, 1, 0);
    cyc(); chk("run_de", 4'b0010, 1, 0);
    cyc(); chk("run_ex", 4'b0100, 1, 0);
    cyc(); chk("run_wb", 4'b1000, 1, 0);
    cyc(); chk("run_if2", 4'b0001, 1, 0);
    cyc(); bus.stop = 1;
    chk("stop_de", 4'b0010, 1, 0);
    cyc(); bus.stop = 0;
    chk("stop_ex", 4'b0100, 1, 0);
    cyc(); chk("stop_wb", 4'b1000, 1, 0);
    cyc(); chk("stopped", 4'b0000, 0, 0);
    bus.step_phase = 1;
    cyc(); bus.step_phase = 0;
    chk("sp_if", 4'b0001, 1, 0);
    cyc(); chk("sp_if_idle", 4'b0000, 0, 0);
    bus.step_phase = 1;
    cyc(); bus.step_phase = 0;
    chk("sp_de", 4'b0010, 1, 0);
    cyc(); chk("sp_de_idle", 4'b0000, 0, 0);
    bus.step_phase = 1;
    cyc(); bus.step_phase = 0;
    chk("sp_ex", 4'b0100, 1, 0);
    cyc(); chk("sp_ex_idle", 4'b0000, 0, 0);
    bus.step_inst = 1;
    cyc(); bus.step_inst = 0;
    chk("si_wb", 4'b1000, 1, 0);
    cyc(); chk("si_idle", 4'b0000, 0, 0);
    bus.bp_en = 1; bus.bp_addr = 32'h10; bus.pc = 32'h0C; bus.run = 1;
    cyc(); bus.run = 0; bus.mem_busy = 1;
    chk("busy_a", 4'b0001, 1, 0);
    cyc(); chk("busy_b", 4'b0001, 1, 0);
    cyc(); chk("busy_c", 4'b0001, 1, 0);
    cyc(); bus.mem_busy = 0;
    chk("busy_d", 4'b0001, 1, 0);
    cyc(); chk("busy_de", 4'b0010, 1, 0);
    cyc(); chk("busy_ex", 4'b0100, 1, 0);
    cyc(); chk("busy_wb", 4'b1000, 1, 0);
    cyc(); bus.pc = 32'h10;
    chk("bp_hit", 4'b0000, 1, 0);
    cyc(); chk("bp_idle", 4'b0000, 0, 1);
    bus.run = 1;
    cyc(); bus.run = 0;
    chk("bp_resume_if", 4'b0001, 1, 0);
    cyc(); chk("bp_resume_de", 4'b0010, 1, 0);
    cyc(); chk("bp_resume_ex", 4'b0100, 1, 0);
    cyc(); chk("bp_resume_wb", 4'b1000, 1, 0);
    cyc(); bus.pc = 32'h14;
    chk("next_if", 4'b0001, 1, 0);
    cyc(); chk("next_de", 4'b0010, 1, 0);
    cyc(); chk("next_ex", 4'b0100, 1, 0);
    rst = 1;
    chk("rst_ex", 4'b0000, 0, 0);
    cyc(); rst = 0;
    chk("rst_after", 4'b0000, 0, 0);
    bus.run = 1;
    cyc(); bus.run = 0;
    chk("rst_run_if", 4'b0001, 1, 0);
    cyc(); chk("rst_run_de", 4'b0010, 1, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
